sc_key_sequencer: RTL

- Front-end controller that sequences raw KEY inputs into the safe-lock FSM.
- Synchronises and debounces the four active-low keys and rejects chords (several keys at once).
- Emits exactly one valid/ready key event per single-key press.
- Aborts a partial code entry after an idle timeout, and suppresses input while the lock reports lockout.

---
 rtl/sc_key_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sc_key_sequencer.sv
// sc_key_sequencer: synchronises and debounces the four active-low KEY inputs,
// rejects chords, offers exactly one valid/ready key event per single-key
// press to the lock FSM, and aborts a stale partial entry after an idle timeout.
module sc_key_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned IDLE_TIMEOUT    = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       lock_busy,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] btn_clean,
  output logic       chord_err,
  output logic       entry_abort
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned IW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OFFER, WAIT_REL, CHORD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1, btn_sync;
  logic [DW-1:0] db_cnt [4];
  logic [3:0]    pressed;
  logic [2:0]    n_pressed;
  logic [3:0]    code_q, code_d;
  logic          deliver;
  logic          entry_active;
  logic [IW-1:0] idle_cnt;
  logic          busy_q, busy_rise;
  logic          idle_run, idle_hit;

  // Two-flop synchroniser for the asynchronous raw keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '1;
      btn_sync <= '1;
    end else begin
      sync1    <= btn_raw;
      btn_sync <= sync1;
    end
  end

  // Per-key debounce: a level is accepted only after DEBOUNCE_CYCLES differing cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_clean <= '1;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (btn_sync[i] == btn_clean[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_clean[i] <= btn_sync[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Number of debounced keys currently held.
  always_comb begin
    pressed   = ~btn_clean;
    n_pressed = '0;
    for (int unsigned i = 0; i < 4; i++) n_pressed = n_pressed + {2'b00, pressed[i]};
  end

  // FSM state and captured key code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '1;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Next-state logic; code_d returns to all-ones whenever the offer ends so key_code idles high.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    chord_err = 1'b0;
    deliver   = 1'b0;
    case (state_q)
      IDLE: begin
        if (n_pressed == 3'd1 && !lock_busy) begin
          code_d  = btn_clean;
          state_d = OFFER;
        end else if (n_pressed >= 3'd2) begin
          chord_err = 1'b1;
          state_d   = CHORD;
        end else if (n_pressed != 3'd0) begin
          state_d = WAIT_REL;
        end
      end
      OFFER: begin
        if (key_ready) begin
          deliver = 1'b1;
          code_d  = '1;
          state_d = WAIT_REL;
        end else if (lock_busy) begin
          code_d  = '1;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL, CHORD: begin
        if (n_pressed == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_valid = (state_q == OFFER);
  assign key_code  = code_q;

  // Idle timeout qualifiers; a lockout edge suppresses the abort pulse in the same cycle.
  always_comb begin
    busy_rise   = lock_busy & ~busy_q;
    idle_run    = (state_q == IDLE) && (n_pressed == 3'd0) && entry_active && !busy_rise;
    idle_hit    = idle_run && (idle_cnt == IDLE_LAST);
    entry_abort = idle_hit;
  end

  // Entry tracking and idle counter; delivery takes precedence over a concurrent lockout edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      entry_active <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      busy_q <= lock_busy;
      if (deliver) entry_active <= 1'b1;
      else if (busy_rise || idle_hit) entry_active <= 1'b0;
      if (idle_run && !idle_hit) idle_cnt <= idle_cnt + 1'b1;
      else idle_cnt <= '0;
    end
  end

endmodule
